// File: rtl/board_click_decoder_if.sv
// Bus bundle for the minesweeper click decoder: pointer/button inputs,
// board geometry, mine maps, and the decoded field command outputs.
interface board_click_decoder_if;
    localparam int unsigned PosW   = 12;
    localparam int unsigned BoardW = 11;
    localparam int unsigned SizeW  = 7;
    localparam int unsigned IdxW   = 5;

    // game and pointer state
    logic [1:0]              level;
    logic [PosW-1:0]         mouse_xpos;
    logic [PosW-1:0]         mouse_ypos;
    logic                    left;
    logic                    right;
    logic                    game_over;

    // board geometry
    logic [BoardW-1:0]       board_xpos;
    logic [BoardW-1:0]       board_ypos;
    logic [SizeW-1:0]        button_size;
    logic [IdxW-1:0]         button_num;

    // mine maps indexed [ind_y][ind_x]
    logic [7:0][7:0]         mine_arr_easy;
    logic [9:0][9:0]         mine_arr_medium;
    logic [15:0][15:0]       mine_arr_hard;

    // decoded command
    logic [IdxW-1:0]         symbol_ind_x;
    logic [IdxW-1:0]         symbol_ind_y;
    logic                    mark_flag;
    logic                    defuse;
    logic                    explode;
    logic                    busy;

    modport slave (
        input  level, mouse_xpos, mouse_ypos, left, right, game_over,
        input  board_xpos, board_ypos, button_size, button_num,
        input  mine_arr_easy, mine_arr_medium, mine_arr_hard,
        output symbol_ind_x, symbol_ind_y, mark_flag, defuse, explode, busy
    );

    modport master (
        output level, mouse_xpos, mouse_ypos, left, right, game_over,
        output board_xpos, board_ypos, button_size, button_num,
        output mine_arr_easy, mine_arr_medium, mine_arr_hard,
        input  symbol_ind_x, symbol_ind_y, mark_flag, defuse, explode, busy
    );
endinterface

// File: rtl/board_click_decoder.sv
// Minesweeper click decoder: converts a mouse button press at a pixel
// position into a field index by repeated subtraction, then issues a
// single-cycle mark_flag / defuse / explode command for that field.
module board_click_decoder (
    input  logic                 clk,
    input  logic                 rst,
    board_click_decoder_if.slave bus
);
    localparam int unsigned PosW = 12;
    localparam int unsigned IdxW = 5;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CALC         = 2'd1,
        ISSUE        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_e;

    state_e            state_q, state_d;

    logic              left_q, right_q;
    logic [PosW-1:0]   x_rem_q, x_rem_d;
    logic [PosW-1:0]   y_rem_q, y_rem_d;
    logic [IdxW-1:0]   idx_x_q, idx_x_d;
    logic [IdxW-1:0]   idx_y_q, idx_y_d;
    logic              x_done_q, x_done_d;
    logic              y_done_q, y_done_d;
    logic              is_right_q, is_right_d;

    logic [IdxW-1:0]   sym_x_q, sym_x_d;
    logic [IdxW-1:0]   sym_y_q, sym_y_d;
    logic              mark_q, mark_d;
    logic              defuse_q, defuse_d;
    logic              explode_q, explode_d;
    logic              busy_q, busy_d;

    logic              left_press_c;
    logic              right_press_c;
    logic              click_ok_c;
    logic              mine_hit_c;
    logic              abort_c;
    logic [PosW-1:0]   size_c;
    logic [PosW-1:0]   bx_c;
    logic [PosW-1:0]   by_c;

    // Operand widening and click qualification
    assign size_c        = PosW'(bus.button_size);
    assign bx_c          = PosW'(bus.board_xpos);
    assign by_c          = PosW'(bus.board_ypos);
    assign left_press_c  = bus.left  & ~left_q;
    assign right_press_c = bus.right & ~right_q;
    assign click_ok_c    = (bus.level != 2'd0) && !bus.game_over &&
                           (bus.mouse_xpos >= bx_c) && (bus.mouse_ypos >= by_c);

    // Mine lookup in the level-selected map at the current field index
    always_comb begin
        mine_hit_c = 1'b0;
        case (bus.level)
            2'd1: begin
                if ((idx_x_q < IdxW'(8)) && (idx_y_q < IdxW'(8)))
                    mine_hit_c = bus.mine_arr_easy[idx_y_q[2:0]][idx_x_q[2:0]];
            end
            2'd2: begin
                if ((idx_x_q < IdxW'(10)) && (idx_y_q < IdxW'(10)))
                    mine_hit_c = bus.mine_arr_medium[idx_y_q[3:0]][idx_x_q[3:0]];
            end
            2'd3: begin
                if ((idx_x_q < IdxW'(16)) && (idx_y_q < IdxW'(16)))
                    mine_hit_c = bus.mine_arr_hard[idx_y_q[3:0]][idx_x_q[3:0]];
            end
            default: mine_hit_c = 1'b0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        x_rem_d    = x_rem_q;
        y_rem_d    = y_rem_q;
        idx_x_d    = idx_x_q;
        idx_y_d    = idx_y_q;
        x_done_d   = x_done_q;
        y_done_d   = y_done_q;
        is_right_d = is_right_q;
        sym_x_d    = sym_x_q;
        sym_y_d    = sym_y_q;
        mark_d     = 1'b0;
        defuse_d   = 1'b0;
        explode_d  = 1'b0;
        abort_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (left_press_c || right_press_c) begin
                    if (click_ok_c) begin
                        // a simultaneous left+right press counts as left
                        x_rem_d    = bus.mouse_xpos - bx_c;
                        y_rem_d    = bus.mouse_ypos - by_c;
                        idx_x_d    = '0;
                        idx_y_d    = '0;
                        x_done_d   = 1'b0;
                        y_done_d   = 1'b0;
                        is_right_d = !left_press_c;
                        state_d    = CALC;
                    end else begin
                        state_d    = WAIT_RELEASE;
                    end
                end
            end

            CALC: begin
                // compare before subtract so the remainder never wraps
                if (!x_done_q) begin
                    if (x_rem_q >= size_c) begin
                        if ((idx_x_q + IdxW'(1)) == bus.button_num) begin
                            abort_c = 1'b1;
                        end else begin
                            x_rem_d = x_rem_q - size_c;
                            idx_x_d = idx_x_q + IdxW'(1);
                        end
                    end else begin
                        x_done_d = 1'b1;
                    end
                end
                if (!y_done_q) begin
                    if (y_rem_q >= size_c) begin
                        if ((idx_y_q + IdxW'(1)) == bus.button_num) begin
                            abort_c = 1'b1;
                        end else begin
                            y_rem_d = y_rem_q - size_c;
                            idx_y_d = idx_y_q + IdxW'(1);
                        end
                    end else begin
                        y_done_d = 1'b1;
                    end
                end

                if (abort_c) begin
                    // click lies right of or below the board
                    state_d = WAIT_RELEASE;
                end else if (x_done_d && y_done_d) begin
                    // indices are final; load them so the pulse lines up with ISSUE
                    state_d = ISSUE;
                    sym_x_d = idx_x_q;
                    sym_y_d = idx_y_q;
                    if (is_right_q)
                        mark_d = 1'b1;
                    else if (mine_hit_c)
                        explode_d = 1'b1;
                    else
                        defuse_d = 1'b1;
                end
            end

            ISSUE: begin
                state_d = WAIT_RELEASE;
            end

            WAIT_RELEASE: begin
                if (!bus.left && !bus.right)
                    state_d = IDLE;
            end

            default: state_d = WAIT_RELEASE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset parks in WAIT_RELEASE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WAIT_RELEASE;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            x_rem_q    <= '0;
            y_rem_q    <= '0;
            idx_x_q    <= '0;
            idx_y_q    <= '0;
            x_done_q   <= 1'b0;
            y_done_q   <= 1'b0;
            is_right_q <= 1'b0;
            sym_x_q    <= '0;
            sym_y_q    <= '0;
            mark_q     <= 1'b0;
            defuse_q   <= 1'b0;
            explode_q  <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            left_q     <= bus.left;
            right_q    <= bus.right;
            x_rem_q    <= x_rem_d;
            y_rem_q    <= y_rem_d;
            idx_x_q    <= idx_x_d;
            idx_y_q    <= idx_y_d;
            x_done_q   <= x_done_d;
            y_done_q   <= y_done_d;
            is_right_q <= is_right_d;
            sym_x_q    <= sym_x_d;
            sym_y_q    <= sym_y_d;
            mark_q     <= mark_d;
            defuse_q   <= defuse_d;
            explode_q  <= explode_d;
            busy_q     <= busy_d;
        end
    end

    // Output drive
    assign bus.symbol_ind_x = sym_x_q;
    assign bus.symbol_ind_y = sym_y_q;
    assign bus.mark_flag    = mark_q;
    assign bus.defuse       = defuse_q;
    assign bus.explode      = explode_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_board_click_decoder.sv
// Directed bench for board_click_decoder: a table of clicks with
// hand-computed commands, indices and latencies, plus sequences for
// held buttons, presses while busy, game_over mid-calculation and reset.
module tb_board_click_decoder;
    logic clk = 1'b0;
    logic rst;

    board_click_decoder_if bus ();

    board_click_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // cmd codes: 0 none, 1 mark_flag, 2 defuse, 3 explode, 9 several at once
    typedef struct {
        int level; int bx; int by; int size; int num;
        int mx; int my; int l; int r; int go;
        int mine; int mine_x; int mine_y;
        int cmd; int ex; int ey; int lat;
    } vec_t;

    vec_t vecs [14];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   last_x = 0;
    int   last_y = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setup(input vec_t v);
        bus.level           = 2'(v.level);
        bus.board_xpos      = 11'(v.bx);
        bus.board_ypos      = 11'(v.by);
        bus.button_size     = 7'(v.size);
        bus.button_num      = 5'(v.num);
        bus.mouse_xpos      = 12'(v.mx);
        bus.mouse_ypos      = 12'(v.my);
        bus.game_over       = 1'(v.go);
        bus.mine_arr_easy   = '0;
        bus.mine_arr_medium = '0;
        bus.mine_arr_hard   = '0;
        if (v.mine != 0) begin
            if (v.level == 1)      bus.mine_arr_easy[v.mine_y][v.mine_x]   = 1'b1;
            else if (v.level == 2) bus.mine_arr_medium[v.mine_y][v.mine_x] = 1'b1;
            else if (v.level == 3) bus.mine_arr_hard[v.mine_y][v.mine_x]   = 1'b1;
        end
    endtask

    // Watch ncyc clock edges; report pulse cycles, first pulse position and its kind
    task automatic observe(input int ncyc, output int cnt, output int lat, output int cmd);
        int k;
        cnt = 0; lat = 0; cmd = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk);
            @(negedge clk);
            k = int'(bus.mark_flag) + int'(bus.defuse) + int'(bus.explode);
            if (k != 0) begin
                cnt++;
                if (lat == 0) begin
                    lat = i;
                    if (k > 1)               cmd = 9;
                    else if (bus.mark_flag)  cmd = 1;
                    else if (bus.defuse)     cmd = 2;
                    else                     cmd = 3;
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && bus.busy !== 1'b0; i++) @(negedge clk);
        check(name, int'(bus.busy), 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cnt, lat, cmd;
        wait_idle($sformatf("v%0d_idle_before", idx));
        @(negedge clk);
        setup(v);
        bus.left  = 1'(v.l);
        bus.right = 1'(v.r);
        observe(30, cnt, lat, cmd);
        check($sformatf("v%0d_cmd", idx), cmd, v.cmd);
        check($sformatf("v%0d_pulses", idx), cnt, (v.cmd != 0) ? 1 : 0);
        if (v.cmd != 0) begin
            check($sformatf("v%0d_latency", idx), lat, v.lat);
            last_x = v.ex;
            last_y = v.ey;
        end
        check($sformatf("v%0d_ind_x", idx), int'(bus.symbol_ind_x), last_x);
        check($sformatf("v%0d_ind_y", idx), int'(bus.symbol_ind_y), last_y);
        check($sformatf("v%0d_busy_held", idx), int'(bus.busy), 1);
        bus.left      = 1'b0;
        bus.right     = 1'b0;
        bus.game_over = 1'b0;
        wait_idle($sformatf("v%0d_idle_after", idx));
    endtask

    initial begin
        int cnt, lat, cmd;

        //           lvl  bx  by  sz num  mx   my  l r go mn mx my cmd ex ey lat
        vecs[0]  = '{1, 100, 50, 40, 8, 185,  95, 1,0,0, 0, 0, 0, 2,  2, 1, 4};
        vecs[1]  = '{1, 100, 50, 40, 8, 185,  95, 1,0,0, 1, 2, 1, 3,  2, 1, 4};
        vecs[2]  = '{1, 100, 50, 40, 8, 420,  60, 0,1,0, 0, 0, 0, 0,  0, 0, 0};
        vecs[3]  = '{1, 100, 50, 40, 8, 100,  50, 0,1,0, 0, 0, 0, 1,  0, 0, 2};
        vecs[4]  = '{1, 100, 50, 40, 8, 185,  95, 0,1,0, 1, 2, 1, 1,  2, 1, 4};
        vecs[5]  = '{1, 100, 50, 40, 8,  99,  60, 1,0,0, 0, 0, 0, 0,  0, 0, 0};
        vecs[6]  = '{1, 100, 50, 40, 8, 185,  95, 1,0,1, 0, 0, 0, 0,  0, 0, 0};
        vecs[7]  = '{0, 100, 50, 40, 8, 185,  95, 1,0,0, 0, 0, 0, 0,  0, 0, 0};
        vecs[8]  = '{3, 100, 50, 20,16, 419, 350, 1,0,0, 1,15,15, 3, 15,15,17};
        vecs[9]  = '{3, 100, 50, 20,16, 419, 350, 1,0,0, 1,14,15, 2, 15,15,17};
        vecs[10] = '{2, 100, 50, 30,10, 399,  79, 1,0,0, 1, 9, 0, 3,  9, 0,11};
        vecs[11] = '{1, 100, 50, 40, 8, 185,  95, 1,1,0, 0, 0, 0, 2,  2, 1, 4};
        vecs[12] = '{1, 100, 50, 40, 8, 100, 369, 0,1,0, 0, 0, 0, 1,  0, 7, 9};
        vecs[13] = '{1, 100, 50, 40, 8, 100, 370, 0,1,0, 0, 0, 0, 0,  0, 0, 0};

        bus.left  = 1'b0;
        bus.right = 1'b0;
        setup(vecs[0]);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy), 1);
        check("rst_ind_x", int'(bus.symbol_ind_x), 0);
        check("rst_ind_y", int'(bus.symbol_ind_y), 0);
        check("rst_pulses", int'(bus.mark_flag) + int'(bus.defuse) + int'(bus.explode), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_idle", int'(bus.busy), 0);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Button held 50 cycles plus a second press while busy: one command only
        wait_idle("hold_idle_before");
        @(negedge clk);
        setup(vecs[0]);
        bus.left = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.right = 1'b1;
        observe(50, cnt, lat, cmd);
        check("hold_pulses", cnt, 1);
        check("hold_cmd", cmd, 2);
        bus.left  = 1'b0;
        bus.right = 1'b0;
        wait_idle("hold_idle_after");

        // game_over rising during CALC does not cancel the command
        @(negedge clk);
        setup(vecs[8]);
        bus.left = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.game_over = 1'b1;
        observe(25, cnt, lat, cmd);
        check("go_mid_cmd", cmd, 3);
        check("go_mid_pulses", cnt, 1);
        check("go_mid_latency", lat, 14);
        check("go_mid_ind_x", int'(bus.symbol_ind_x), 15);
        check("go_mid_ind_y", int'(bus.symbol_ind_y), 15);
        bus.left      = 1'b0;
        bus.game_over = 1'b0;
        wait_idle("go_mid_idle_after");

        // Reset mid-CALC with the button held: command dropped, busy until release
        @(negedge clk);
        setup(vecs[8]);
        bus.left = 1'b1;
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_busy", int'(bus.busy), 1);
        check("mid_rst_ind_x", int'(bus.symbol_ind_x), 0);
        check("mid_rst_ind_y", int'(bus.symbol_ind_y), 0);
        last_x = 0;
        last_y = 0;
        @(negedge clk);
        rst = 1'b1;
        observe(30, cnt, lat, cmd);
        check("mid_rst_pulses", cnt, 0);
        check("mid_rst_busy_held", int'(bus.busy), 1);
        check("mid_rst_ind_x_hold", int'(bus.symbol_ind_x), 0);
        bus.left = 1'b0;
        wait_idle("mid_rst_release");
        run_vec(100, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule
